// File: rtl/gate_cal_ctrl.sv
// Noise-gate calibration controller: measures mean RMS over 2^LOG2_CAL samples and writes threshold = mean x margin.
// Optional define GATE_CAL_MANUAL_EN adds a direct threshold write port (thresh_wr / thresh_wdata), honoured only in IDLE.
module gate_cal_ctrl #(
    parameter int          SETTLE_SAMPLES = 256,
    parameter int          LOG2_CAL       = 10,
    parameter logic [15:0] MARGIN_Q8      = 16'd384,
    parameter logic [15:0] THRESH_MIN     = 16'd256,
    parameter logic [15:0] THRESH_DEFAULT = 16'd1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [15:0] rms_in,
    input  logic        cal_start,
    input  logic        cal_abort,
`ifdef GATE_CAL_MANUAL_EN
    input  logic        thresh_wr,
    input  logic [15:0] thresh_wdata,
`endif
    output logic [15:0] thresh_q15,
    output logic        cal_busy,
    output logic        mute,
    output logic        cal_done,
    output logic [1:0]  cal_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_COMPUTE = 2'd3
    } state_t;

    localparam int ACC_W = 16 + LOG2_CAL;
    localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int CNT_W = (SET_W > LOG2_CAL + 1) ? SET_W : LOG2_CAL + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'((32'd1 << LOG2_CAL) - 32'd1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [15:0]        r_thresh;
    logic               r_busy;
    logic               r_done;

    logic [15:0]        w_mean;
    logic [23:0]        w_scaled;
    logic [15:0]        w_thresh;

    // Threshold arithmetic reads only registered accumulator state, so no input reaches an output combinationally.
    assign w_mean   = 16'(r_acc >> LOG2_CAL);
    assign w_scaled = 24'((32'(w_mean) * 32'(MARGIN_Q8)) >> 8);

    always_comb begin
        w_thresh = (w_scaled > 24'h007FFF) ? 16'h7FFF : w_scaled[15:0];
        if (w_thresh < THRESH_MIN) begin
            w_thresh = THRESH_MIN;
        end
    end

`ifdef GATE_CAL_MANUAL_EN
    logic [15:0] w_wr_val;
    assign w_wr_val = (thresh_wdata > 16'h7FFF) ? 16'h7FFF : thresh_wdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_thresh <= THRESH_DEFAULT;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
`ifdef GATE_CAL_MANUAL_EN
                    if (thresh_wr) begin
                        r_thresh <= w_wr_val;
                    end
`endif
                    // Abort alongside start cancels the start even from IDLE.
                    if (cal_start && !cal_abort) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cal_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (s_valid) begin
                        if (r_cnt == SETTLE_LAST) begin
                            r_state <= ST_MEASURE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (cal_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (s_valid) begin
                        r_acc <= r_acc + ACC_W'(rms_in);
                        if (r_cnt == MEAS_LAST) begin
                            r_state <= ST_COMPUTE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!cal_abort) begin
                        r_thresh <= w_thresh;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign thresh_q15 = r_thresh;
    assign cal_busy   = r_busy;
    assign mute       = r_busy;
    assign cal_done   = r_done;
    assign cal_state  = r_state;

endmodule
